// File: rtl/sd_arbiter_pkg.sv
// Shared types and constants for the two-requester SD block arbiter.
// Optional macro SD_ARB_TIMEOUT_EN adds the ABORT state used by the watchdog.
package sd_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int BLK_W   = 4096;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
`ifdef SD_ARB_TIMEOUT_EN
        , ST_ABORT = 2'd3
`endif
    } sd_arbiter_fsm_t;

endpackage

// File: rtl/sd_block_arbiter_if.sv
// Requester-side and sd_controller-side Wishbone block bus of the arbiter.
// slave = arbiter view, master = surrounding environment view.
interface sd_block_arbiter_if;
    import sd_arbiter_pkg::*;

    logic [NUM_REQ-1:0]            req_cyc_i;
    logic [NUM_REQ-1:0]            req_stb_i;
    logic [NUM_REQ-1:0]            req_we_i;
    logic [NUM_REQ-1:0][31:0]      req_addr_i;
    logic [NUM_REQ-1:0][BLK_W-1:0] req_dat_i;
    logic [BLK_W-1:0]              req_dat_o;
    logic [NUM_REQ-1:0]            req_ack_o;
    logic [NUM_REQ-1:0]            req_err_o;

    logic                          sd_cyc_o;
    logic                          sd_stb_o;
    logic                          sd_we_o;
    logic [31:0]                   sd_addr_o;
    logic [BLK_W-1:0]              sd_dat_o;
    logic [BLK_W-1:0]              sd_dat_i;
    logic                          sd_ack_i;

    modport slave (
        input  req_cyc_i, req_stb_i, req_we_i, req_addr_i, req_dat_i, sd_dat_i, sd_ack_i,
        output req_dat_o, req_ack_o, req_err_o, sd_cyc_o, sd_stb_o, sd_we_o, sd_addr_o, sd_dat_o
    );

    modport master (
        output req_cyc_i, req_stb_i, req_we_i, req_addr_i, req_dat_i, sd_dat_i, sd_ack_i,
        input  req_dat_o, req_ack_o, req_err_o, sd_cyc_o, sd_stb_o, sd_we_o, sd_addr_o, sd_dat_o
    );

endinterface

// File: rtl/rr_picker2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time goes.
module rr_picker2 (
    input  logic [1:0] i_pending,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_valid
);

    assign o_valid = |i_pending;
    assign o_grant = (&i_pending) ? ~i_last_grant : i_pending[1];

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares one sd_controller Wishbone slave between two block requesters.
// Define SD_ARB_TIMEOUT_EN to enable the BUSY watchdog (TimeoutCycles) and ABORT state.
module sd_block_arbiter
    import sd_arbiter_pkg::*;
#(
    parameter logic [31:0] TimeoutCycles = 32'd50_000_000
) (
    input  logic               clock,
    input  logic               reset,
    sd_block_arbiter_if.slave  bus
);

    sd_arbiter_fsm_t    r_state;
    logic               r_grant;
    logic               r_last_grant;
    logic               r_dropped;
    logic               r_sd_cyc;
    logic               r_sd_stb;
    logic               r_sd_we;
    logic [31:0]        r_sd_addr;
    logic [BLK_W-1:0]   r_sd_dat;
    logic [BLK_W-1:0]   r_req_dat;
    logic [NUM_REQ-1:0] r_req_ack;

    logic [NUM_REQ-1:0] w_pending;
    logic               w_pick;
    logic               w_pick_vld;
    logic               w_grant_cyc;
    logic               w_grant_rel;

    assign w_pending   = bus.req_cyc_i & bus.req_stb_i;
    assign w_grant_cyc = bus.req_cyc_i[r_grant];
    assign w_grant_rel = !bus.req_cyc_i[r_grant] || !bus.req_stb_i[r_grant];

    rr_picker2 u_pick (
        .i_pending    (w_pending),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick),
        .o_valid      (w_pick_vld)
    );

`ifdef SD_ARB_TIMEOUT_EN
    logic [31:0]        r_tmo_cnt;
    logic [NUM_REQ-1:0] r_req_err;
    assign bus.req_err_o = r_req_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo  = ^TimeoutCycles;
    assign bus.req_err_o = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_dropped    <= 1'b0;
            r_sd_cyc     <= 1'b0;
            r_sd_stb     <= 1'b0;
            r_sd_we      <= 1'b0;
            r_sd_addr    <= '0;
            r_sd_dat     <= '0;
            r_req_dat    <= '0;
            r_req_ack    <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_req_err    <= '0;
`endif
        end else begin
            r_req_ack <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            r_req_err <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_dropped    <= 1'b0;
                        r_sd_cyc     <= 1'b1;
                        r_sd_stb     <= 1'b1;
                        r_sd_we      <= bus.req_we_i[w_pick];
                        r_sd_addr    <= bus.req_addr_i[w_pick];
                        r_sd_dat     <= bus.req_dat_i[w_pick];
`ifdef SD_ARB_TIMEOUT_EN
                        r_tmo_cnt    <= '0;
`endif
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // The sd_controller cannot be aborted, so a requester that
                    // walks away only loses its ack; the transfer still completes.
                    if (!w_grant_cyc) r_dropped <= 1'b1;
                    if (bus.sd_ack_i) begin
                        r_sd_cyc <= 1'b0;
                        r_sd_stb <= 1'b0;
                        if (!r_sd_we) r_req_dat <= bus.sd_dat_i;
                        if (r_dropped || !w_grant_cyc) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_req_ack[r_grant] <= 1'b1;
                            r_state            <= ST_RELEASE;
                        end
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == TimeoutCycles - 32'd1) begin
                        r_sd_cyc           <= 1'b0;
                        r_sd_stb           <= 1'b0;
                        r_req_err[r_grant] <= 1'b1;
                        r_state            <= ST_ABORT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (w_grant_rel) r_state <= ST_IDLE;
                end
`ifdef SD_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    // Late sd_ack_i is deliberately ignored here.
                    if (w_grant_rel) r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sd_cyc_o  = r_sd_cyc;
    assign bus.sd_stb_o  = r_sd_stb;
    assign bus.sd_we_o   = r_sd_we;
    assign bus.sd_addr_o = r_sd_addr;
    assign bus.sd_dat_o  = r_sd_dat;
    assign bus.req_dat_o = r_req_dat;
    assign bus.req_ack_o = r_req_ack;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Self-checking bench for sd_block_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin transaction-level model.
module tb_sd_block_arbiter;
    import sd_arbiter_pkg::*;

    localparam logic [31:0] TMO = 32'd100;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sd_block_arbiter_if bus();

    sd_block_arbiter #(.TimeoutCycles(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model state: last granted requester and the block req_dat_o should hold.
    int               last_g;
    logic [BLK_W-1:0] exp_rdat;
    int               nrise;
    logic             prev_stb;

    function automatic int rr_pick(input logic [1:0] pend, input int last);
        if (pend == 2'b11) return 1 - last;
        return pend[1] ? 1 : 0;
    endfunction

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLK_W / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic tick();
        @(negedge clock);
        if (bus.sd_stb_o && !prev_stb) nrise++;
        prev_stb = bus.sd_stb_o;
    endtask

    task automatic idle_inputs();
        bus.req_cyc_i  = '0;
        bus.req_stb_i  = '0;
        bus.req_we_i   = '0;
        bus.req_addr_i = '0;
        bus.req_dat_i  = '0;
        bus.sd_dat_i   = '0;
        bus.sd_ack_i   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        last_g   = 1;
        exp_rdat = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        prev_stb = 1'b0;
        nrise    = 0;
        bus.req_cyc_i = 2'b11;
        bus.req_stb_i = 2'b11;
        bus.req_addr_i[0] = 32'hDEAD_0000;
        bus.req_dat_i[0]  = rand_blk();
        reset = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({bus.sd_cyc_o, bus.sd_stb_o, bus.sd_we_o} !== 3'b000) begin
            errors++; $display("FAIL reset_sd_ctl got=%b want=000", {bus.sd_cyc_o, bus.sd_stb_o, bus.sd_we_o});
        end
        checks++;
        if (bus.sd_addr_o !== 32'h0 || bus.sd_dat_o !== '0) begin
            errors++; $display("FAIL reset_sd_addr_dat addr=%h dat_lo=%h want=0", bus.sd_addr_o, bus.sd_dat_o[31:0]);
        end
        checks++;
        if (bus.req_dat_o !== '0 || bus.req_ack_o !== 2'b00 || bus.req_err_o !== 2'b00) begin
            errors++; $display("FAIL reset_req_out dat_lo=%h ack=%b err=%b want=0", bus.req_dat_o[31:0], bus.req_ack_o, bus.req_err_o);
        end
        idle_inputs();
        reset = 1'b0;
        last_g   = 1;
        exp_rdat = '0;
        tick();
    endtask

    task automatic test_single_read();
        logic [BLK_W-1:0] d;
        d = rand_blk();
        bus.req_cyc_i = 2'b01;
        bus.req_stb_i = 2'b01;
        bus.req_we_i  = 2'b00;
        bus.req_addr_i[0] = 32'h10;
        tick();
        checks++;
        if (bus.sd_stb_o !== 1'b1 || bus.sd_cyc_o !== 1'b1 || bus.sd_addr_o !== 32'h10 || bus.sd_we_o !== 1'b0) begin
            errors++; $display("FAIL read_issue stb=%b cyc=%b addr=%h we=%b want=1 1 10 0", bus.sd_stb_o, bus.sd_cyc_o, bus.sd_addr_o, bus.sd_we_o);
        end
        last_g = 0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.sd_stb_o !== 1'b1 || bus.req_ack_o !== 2'b00) begin
            errors++; $display("FAIL read_wait stb=%b ack=%b want=1 00", bus.sd_stb_o, bus.req_ack_o);
        end
        bus.sd_dat_i = d;
        bus.sd_ack_i = 1'b1;
        tick();
        bus.sd_ack_i = 1'b0;
        exp_rdat = d;
        checks++;
        if (bus.req_ack_o !== 2'b01 || bus.sd_stb_o !== 1'b0 || bus.sd_cyc_o !== 1'b0) begin
            errors++; $display("FAIL read_ack ack=%b stb=%b cyc=%b want=01 0 0", bus.req_ack_o, bus.sd_stb_o, bus.sd_cyc_o);
        end
        checks++;
        if (bus.req_dat_o !== exp_rdat) begin
            errors++; $display("FAIL read_data got_lo=%h want_lo=%h", bus.req_dat_o[31:0], exp_rdat[31:0]);
        end
        tick();
        checks++;
        if (bus.req_ack_o !== 2'b00) begin
            errors++; $display("FAIL read_ack_pulse got=%b want=00", bus.req_ack_o);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        for (int it = 0; it < 3; it++) begin
            logic [BLK_W-1:0] d;
            d = rand_blk();
            g = rr_pick(2'b11, last_g);
            bus.req_addr_i[0] = 32'h100 + it;
            bus.req_addr_i[1] = 32'h200 + it;
            bus.req_we_i  = 2'b00;
            bus.req_cyc_i = 2'b11;
            bus.req_stb_i = 2'b11;
            nrise = 0;
            tick();
            checks++;
            if (bus.sd_addr_o !== (g == 1 ? 32'h200 + it : 32'h100 + it)) begin
                errors++; $display("FAIL rr_grant it=%0d addr=%h want_req=%0d", it, bus.sd_addr_o, g);
            end
            tick();
            tick();
            bus.sd_dat_i = d;
            bus.sd_ack_i = 1'b1;
            tick();
            bus.sd_ack_i = 1'b0;
            exp_rdat = d;
            checks++;
            if (bus.req_ack_o !== (2'b01 << g)) begin
                errors++; $display("FAIL rr_ack it=%0d got=%b want=%b", it, bus.req_ack_o, 2'b01 << g);
            end
            tick();
            tick();
            bus.req_cyc_i = 2'b00;
            bus.req_stb_i = 2'b00;
            tick();
            tick();
            checks++;
            if (nrise !== 1) begin
                errors++; $display("FAIL rr_txn_count it=%0d got=%0d want=1", it, nrise);
            end
            last_g = g;
        end
    endtask

    task automatic test_write();
        logic [BLK_W-1:0] d;
        logic [31:0]      a;
        d = {512{8'hA5}};
        a = $urandom;
        bus.req_cyc_i = 2'b10;
        bus.req_stb_i = 2'b10;
        bus.req_we_i  = 2'b10;
        bus.req_addr_i[1] = a;
        bus.req_dat_i[1]  = d;
        tick();
        last_g = 1;
        checks++;
        if (bus.sd_we_o !== 1'b1 || bus.sd_addr_o !== a || bus.sd_dat_o !== d) begin
            errors++; $display("FAIL write_issue we=%b addr=%h dat_lo=%h want=1 %h a5a5a5a5", bus.sd_we_o, bus.sd_addr_o, bus.sd_dat_o[31:0], a);
        end
        bus.sd_dat_i = rand_blk();
        tick();
        bus.sd_ack_i = 1'b1;
        tick();
        bus.sd_ack_i = 1'b0;
        checks++;
        if (bus.req_ack_o !== 2'b10 || bus.req_dat_o !== exp_rdat) begin
            errors++; $display("FAIL write_ack ack=%b dat_lo=%h want=10 %h", bus.req_ack_o, bus.req_dat_o[31:0], exp_rdat[31:0]);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_hold_stb();
        logic [BLK_W-1:0] d;
        int bad;
        d = rand_blk();
        bus.req_cyc_i = 2'b01;
        bus.req_stb_i = 2'b01;
        bus.req_we_i  = 2'b00;
        bus.req_addr_i[0] = 32'h40;
        tick();
        last_g = 0;
        bus.sd_dat_i = d;
        bus.sd_ack_i = 1'b1;
        tick();
        bus.sd_ack_i = 1'b0;
        exp_rdat = d;
        checks++;
        if (bus.req_ack_o !== 2'b01 || bus.req_dat_o !== exp_rdat) begin
            errors++; $display("FAIL hold_ack ack=%b dat_lo=%h want=01 %h", bus.req_ack_o, bus.req_dat_o[31:0], exp_rdat[31:0]);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.sd_stb_o !== 1'b0 || bus.req_ack_o !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_no_reissue bad_cycles=%0d want=0", bad);
        end
        bus.req_stb_i = 2'b00;
        tick();
        bus.req_stb_i = 2'b01;
        bus.req_addr_i[0] = 32'h44;
        tick();
        checks++;
        if (bus.sd_stb_o !== 1'b1 || bus.sd_addr_o !== 32'h44) begin
            errors++; $display("FAIL hold_regrant stb=%b addr=%h want=1 44", bus.sd_stb_o, bus.sd_addr_o);
        end
        bus.sd_ack_i = 1'b1;
        tick();
        bus.sd_ack_i = 1'b0;
        exp_rdat = d;
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_drop_cyc();
        logic [BLK_W-1:0] d;
        int bad;
        d = rand_blk();
        bus.req_cyc_i = 2'b01;
        bus.req_stb_i = 2'b01;
        bus.req_we_i  = 2'b00;
        bus.req_addr_i[0] = 32'h77;
        tick();
        last_g = 0;
        bus.req_cyc_i = 2'b00;
        bus.req_stb_i = 2'b00;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.sd_stb_o !== 1'b1 || bus.sd_addr_o !== 32'h77 || bus.req_ack_o !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL drop_keep_running bad_cycles=%0d want=0", bad);
        end
        bus.sd_dat_i = d;
        bus.sd_ack_i = 1'b1;
        tick();
        bus.sd_ack_i = 1'b0;
        exp_rdat = d;
        checks++;
        if (bus.req_ack_o !== 2'b00 || bus.sd_stb_o !== 1'b0) begin
            errors++; $display("FAIL drop_no_ack ack=%b stb=%b want=00 0", bus.req_ack_o, bus.sd_stb_o);
        end
        bus.req_cyc_i = 2'b10;
        bus.req_stb_i = 2'b10;
        bus.req_addr_i[1] = 32'h88;
        tick();
        checks++;
        if (bus.sd_stb_o !== 1'b1 || bus.sd_addr_o !== 32'h88 || bus.req_ack_o !== 2'b00) begin
            errors++; $display("FAIL drop_next_grant stb=%b addr=%h ack=%b want=1 88 00", bus.sd_stb_o, bus.sd_addr_o, bus.req_ack_o);
        end
        last_g = 1;
        bus.sd_ack_i = 1'b1;
        tick();
        bus.sd_ack_i = 1'b0;
        checks++;
        if (bus.req_ack_o !== 2'b10) begin
            errors++; $display("FAIL drop_next_ack got=%b want=10", bus.req_ack_o);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 24; r++) begin
            logic [1:0]       pend;
            logic [1:0]       we;
            logic [1:0][31:0] addr;
            logic [1:0][BLK_W-1:0] dat;
            logic [BLK_W-1:0] rd;
            int g, lat, bad;
            pend = 2'($urandom_range(1, 3));
            we   = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                addr[k] = $urandom;
                dat[k]  = rand_blk();
            end
            g   = rr_pick(pend, last_g);
            lat = $urandom_range(0, 4);
            bus.req_cyc_i  = pend;
            bus.req_stb_i  = pend;
            bus.req_we_i   = we;
            bus.req_addr_i = addr;
            bus.req_dat_i  = dat;
            tick();
            checks++;
            if (bus.sd_stb_o !== 1'b1 || bus.sd_addr_o !== addr[g] || bus.sd_we_o !== we[g] || bus.sd_dat_o !== dat[g]) begin
                errors++; $display("FAIL rand_issue r=%0d stb=%b addr=%h we=%b want=1 %h %b (req %0d)", r, bus.sd_stb_o, bus.sd_addr_o, bus.sd_we_o, addr[g], we[g], g);
            end
            bad = 0;
            for (int i = 0; i < lat; i++) begin
                tick();
                if ({bus.sd_cyc_o, bus.sd_stb_o, bus.req_ack_o} !== 4'b1100 || bus.sd_addr_o !== addr[g]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rand_stable r=%0d bad_cycles=%0d want=0", r, bad);
            end
            rd = rand_blk();
            bus.sd_dat_i = rd;
            bus.sd_ack_i = 1'b1;
            tick();
            bus.sd_ack_i = 1'b0;
            if (!we[g]) exp_rdat = rd;
            last_g = g;
            checks++;
            if (bus.req_ack_o !== (2'b01 << g) || bus.req_err_o !== 2'b00 || bus.req_dat_o !== exp_rdat) begin
                errors++; $display("FAIL rand_ack r=%0d ack=%b err=%b dat_lo=%h want=%b 00 %h", r, bus.req_ack_o, bus.req_err_o, bus.req_dat_o[31:0], 2'b01 << g, exp_rdat[31:0]);
            end
            idle_inputs();
            tick();
            tick();
        end
    endtask

    task automatic test_mid_reset();
        bus.req_cyc_i = 2'b01;
        bus.req_stb_i = 2'b01;
        bus.req_addr_i[0] = 32'h99;
        tick();
        reset = 1'b1;
        tick();
        idle_inputs();
        reset = 1'b0;
        last_g   = 1;
        exp_rdat = '0;
        tick();
        checks++;
        if (bus.sd_stb_o !== 1'b0 || bus.req_ack_o !== 2'b00 || bus.req_dat_o !== '0) begin
            errors++; $display("FAIL mid_reset stb=%b ack=%b dat_lo=%h want=0 00 0", bus.sd_stb_o, bus.req_ack_o, bus.req_dat_o[31:0]);
        end
    endtask

`ifdef SD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        bus.req_cyc_i = 2'b01;
        bus.req_stb_i = 2'b01;
        bus.req_we_i  = 2'b00;
        bus.req_addr_i[0] = 32'h55;
        tick();
        last_g = 0;
        bad = 0;
        for (int i = 1; i <= int'(TMO); i++) begin
            if (bus.req_err_o !== 2'b00 || bus.sd_stb_o !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL tmo_early bad_cycles=%0d want=0", bad);
        end
        checks++;
        if (bus.req_err_o !== 2'b01 || bus.sd_stb_o !== 1'b0 || bus.sd_cyc_o !== 1'b0) begin
            errors++; $display("FAIL tmo_err err=%b stb=%b cyc=%b want=01 0 0", bus.req_err_o, bus.sd_stb_o, bus.sd_cyc_o);
        end
        tick();
        bus.sd_dat_i = rand_blk();
        bus.sd_ack_i = 1'b1;
        checks++;
        if (bus.req_err_o !== 2'b00) begin
            errors++; $display("FAIL tmo_err_pulse got=%b want=00", bus.req_err_o);
        end
        tick();
        bus.sd_ack_i = 1'b0;
        checks++;
        if (bus.req_ack_o !== 2'b00 || bus.req_dat_o !== exp_rdat || bus.sd_stb_o !== 1'b0) begin
            errors++; $display("FAIL tmo_late_ack ack=%b dat_lo=%h stb=%b want=00 %h 0", bus.req_ack_o, bus.req_dat_o[31:0], bus.sd_stb_o, exp_rdat[31:0]);
        end
        idle_inputs();
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_hold_stb();
        test_drop_cyc();
        test_random();
        test_mid_reset();
`ifdef SD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_block_arbiter.md
SD_BLOCK_ARBITER -- requirements
Module: sd_block_arbiter

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 32'd50_000_000: watchdog limit in clock cycles, active only under SD_ARB_TIMEOUT_EN.
REQ-002 SHALL have port clock  input  1  system clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_cyc_i  input  [1:0]  per-requester Wishbone cycle.
REQ-005 SHALL have port req_stb_i  input  [1:0]  per-requester strobe.
REQ-006 SHALL have port req_we_i  input  [1:0]  per-requester write enable.
REQ-007 SHALL have port req_addr_i  input  [1:0][31:0]  per-requester block address.
REQ-008 SHALL have port req_dat_i  input  [1:0][4095:0]  per-requester write block.
REQ-009 SHALL have port req_dat_o  output  4096  read block, shared by both requesters.
REQ-010 SHALL have port req_ack_o  output  [1:0]  per-requester acknowledge.
REQ-011 SHALL have port req_err_o  output  [1:0]  per-requester error, timeout only.
REQ-012 SHALL have port sd_cyc_o / sd_stb_o / sd_we_o  output  1 each  to the sd_controller Wishbone slave.
REQ-013 SHALL have port sd_addr_o  output  32  and sd_dat_o  output  4096  to the sd_controller.
REQ-014 SHALL have port sd_dat_i  input  4096  and sd_ack_i  input  1  from the sd_controller.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RELEASE, plus ABORT when SD_ARB_TIMEOUT_EN is defined.
REQ-016 A requester is pending when its cyc and stb are both high; in IDLE the FSM SHALL grant a pending requester and enter BUSY on the next edge.
REQ-017 On simultaneous requests it SHALL grant the requester other than last_grant; last_grant SHALL be updated on every grant (round robin).
REQ-018 In BUSY it SHALL drive sd_cyc_o=sd_stb_o=1 and register sd_we_o, sd_addr_o and sd_dat_o from the granted requester at grant time; these SHALL stay stable until ack.
REQ-019 On sd_ack_i in BUSY it SHALL, on the next edge, pulse req_ack_o[grant] for exactly 1 cycle, latch sd_dat_i into req_dat_o, drop sd_cyc_o/sd_stb_o and enter RELEASE.
REQ-020 req_dat_o SHALL hold the last read block until the next read ack; write acks SHALL leave it unchanged.
REQ-021 In RELEASE it SHALL wait until req_stb_i[grant]=0 or req_cyc_i[grant]=0, then return to IDLE; a new grant SHALL never occur in the same cycle.
REQ-022 If the granted requester drops cyc in BUSY, it SHALL keep the sd transaction running to ack (the sd_controller cannot be aborted), suppress req_ack_o, then go to IDLE.
REQ-023 The minimum turnaround SHALL be request to sd_stb_o in 1 cycle and sd_ack_i to req_ack_o in 1 cycle.
REQ-024 The non-granted requester SHALL see req_ack_o=0 and req_err_o=0 throughout.

Reset
REQ-025 While reset is high on a clock edge: state=IDLE, last_grant=1 (so requester 0 wins first), sd_cyc_o=sd_stb_o=sd_we_o=0, sd_addr_o=0, sd_dat_o=0, req_dat_o=0, req_ack_o=0, req_err_o=0, timeout counter=0.
REQ-026 Reset asserted mid-transaction SHALL abandon it without an ack; the sd_controller is reset by the same signal.

Configuration
REQ-027 With SD_ARB_TIMEOUT_EN defined, a 32-bit counter SHALL count BUSY cycles; when it reaches TimeoutCycles, the block SHALL pulse req_err_o[grant] for 1 cycle, hold sd_cyc_o/sd_stb_o low and enter ABORT.
REQ-028 In ABORT it SHALL discard any late sd_ack_i, wait for requester release as in RELEASE, then go to IDLE.
REQ-029 Without SD_ARB_TIMEOUT_EN: no counter and no ABORT state, req_err_o SHALL be constant 0, and TimeoutCycles SHALL be ignored.

Structure
REQ-030 The sd_arbiter_fsm_t enum and the requester count constant (2) SHALL live in a shared package sd_arbiter_pkg.
REQ-031 The round-robin priority pick SHALL be a sub-module rr_picker2 (pending[1:0], last_grant -> grant index, valid).

Verification
REQ-032 After reset, assert only requester 0 read at addr 0x10 with a slave ack 5 cycles later -> sd_addr_o=0x10, req_ack_o=2'b01 for 1 cycle, req_dat_o=slave data.
REQ-033 Both requesters pending from IDLE three times in a row -> grants 0,1,0 and exactly one sd transaction per grant.
REQ-034 Requester 1 write with req_dat_i[1]=all 0xA5 -> sd_we_o=1, sd_dat_o=0xA5.., req_dat_o unchanged after ack.
REQ-035 Requester holds stb high 10 cycles after ack -> no second sd_stb_o until stb drops, then IDLE.
REQ-036 Requester drops cyc in BUSY, ack arrives later -> no req_ack_o pulse, FSM returns to IDLE, next grant is served.
REQ-037 SD_ARB_TIMEOUT_EN with TimeoutCycles=100 and no ack -> req_err_o[grant] pulses at BUSY cycle 100, and a late ack is ignored.
